// File: rtl/io_input_conditioner.sv
// Switch/pushbutton conditioner: 2-flop sync, per-input debounce, sticky key-press flags, press counter.
// Latency: a held raw change reaches the debounced outputs on rising edge DB_LIMIT+2 after it is first sampled.
// Backpressure: none; free-running, every output is a register readable at any time.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   sw[9:0]           raw slide switches (1 = on)
//   key[3:0]          raw pushbuttons, active-low (0 = pressed)
//   ev_clr[3:0]       per-key clear of the sticky press flags
//   cnt_clr           clear of the press counter
//   sw_value          {22'b0, debounced sw}
//   key_state         {28'b0, debounced keys, 1 = pressed}
//   key_event         {28'b0, sticky press flags}
//   key_count         {16'b0, press counter}
// Optional feature: define IO_PRESS_COUNT_EN to build the press counter; otherwise
// key_count reads 32'h0 and cnt_clr is ignored.
module io_input_conditioner #(
    parameter int DB_LIMIT = 50000,
    parameter int DB_CNT_W = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  sw,
    input  logic [3:0]  key,
    input  logic [3:0]  ev_clr,
    input  logic        cnt_clr,
    output logic [31:0] sw_value,
    output logic [31:0] key_state,
    output logic [31:0] key_event,
    output logic [31:0] key_count
);

    localparam int N_IN = 14;
    // Keys idle high (released), switches idle low.
    localparam logic [N_IN-1:0] RST_LVL = {4'hF, 10'h000};
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_LIMIT - 1);

    // Bit layout of all per-input vectors: [13:10] keys, [9:0] switches.
    logic [N_IN-1:0]     sync1;
    logic [N_IN-1:0]     sync2;
    logic [N_IN-1:0]     stable;
    logic [DB_CNT_W-1:0] db_cnt [N_IN];
    logic [3:0]          press_evt;
    logic [2:0]          n_evt;
    logic [3:0]          key_flag;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1  <= RST_LVL;
            sync2  <= RST_LVL;
            stable <= RST_LVL;
            for (int i = 0; i < N_IN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= {key, sw};
            sync2 <= sync1;
            for (int i = 0; i < N_IN; i++) begin
                if (sync2[i] == stable[i]) begin
                    // Any reversion restarts qualification from zero.
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is the cycle in which a key's stable level is about to go 1->0,
    // so flags and counter update on the same edge as the stable register.
    always_comb begin
        press_evt = '0;
        n_evt     = '0;
        for (int k = 0; k < 4; k++) begin
            press_evt[k] = stable[10+k] & ~sync2[10+k] & (db_cnt[10+k] == DB_LAST);
            n_evt        = n_evt + 3'(press_evt[k]);
        end
    end

    // Set has priority over a coincident clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_flag <= '0;
        end else begin
            key_flag <= (key_flag & ~ev_clr) | press_evt;
        end
    end

`ifdef IO_PRESS_COUNT_EN
    logic [15:0] press_cnt;

    // A clear coinciding with presses loads the presses of that edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            press_cnt <= '0;
        end else if (cnt_clr) begin
            press_cnt <= {13'b0, n_evt};
        end else begin
            press_cnt <= press_cnt + {13'b0, n_evt};
        end
    end

    assign key_count = {16'b0, press_cnt};
`else
    logic unused_cnt_in;
    assign unused_cnt_in = ^{cnt_clr, n_evt};
    assign key_count     = 32'h0;
`endif

    assign sw_value  = {22'b0, stable[9:0]};
    assign key_state = {28'b0, ~stable[13:10]};
    assign key_event = {28'b0, key_flag};

endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;

`ifdef IO_PRESS_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic [9:0]  sw;
    logic [3:0]  key;
    logic [3:0]  ev_clr;
    logic        cnt_clr;
    logic [31:0] sw_value, key_state, key_event, key_count;

    // Second instance with the shortest legal debounce, used for the counter wrap.
    logic [3:0]  w_key;
    logic [31:0] w_sw_value, w_key_state, w_key_event, w_key_count;

    int n_cmp = 0;
    int n_err = 0;

    io_input_conditioner #(.DB_LIMIT(4), .DB_CNT_W(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .sw       (sw),
        .key      (key),
        .ev_clr   (ev_clr),
        .cnt_clr  (cnt_clr),
        .sw_value (sw_value),
        .key_state(key_state),
        .key_event(key_event),
        .key_count(key_count)
    );

    io_input_conditioner #(.DB_LIMIT(2), .DB_CNT_W(16)) u_wrap (
        .clock    (clock),
        .reset    (reset),
        .sw       (10'h000),
        .key      (w_key),
        .ev_clr   (4'h0),
        .cnt_clr  (1'b0),
        .sw_value (w_sw_value),
        .key_state(w_key_state),
        .key_event(w_key_event),
        .key_count(w_key_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    function automatic logic [31:0] exp_cnt(input logic [31:0] v);
        return CNT_EN ? v : 32'h0;
    endfunction

    initial begin
        reset = 1'b1; sw = '0; key = 4'hF; ev_clr = '0; cnt_clr = 1'b0; w_key = 4'hF;
        step(2);
        reset = 1'b0;
        step(1);
        chk("rst_sw_value",  sw_value,  32'h0);
        chk("rst_key_state", key_state, 32'h0);
        chk("rst_key_event", key_event, 32'h0);
        chk("rst_key_count", key_count, 32'h0);
        step(20);
        chk("idle_key_event", key_event, 32'h0);

        // Switch change: visible only after the 6th edge.
        sw = 10'h155;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            chk($sformatf("sw_dly_e%0d", i), sw_value, (i == 6) ? 32'h155 : 32'h0);
        end
        chk("sw_no_event", key_event, 32'h0);

        // 3-cycle glitch on key[0] must be rejected.
        key = 4'hE; step(3); key = 4'hF; step(10);
        chk("glitch_state", key_state, 32'h0);
        chk("glitch_event", key_event, 32'h0);
        chk("glitch_count", key_count, 32'h0);

        // key[2] held low 10 cycles.
        key = 4'hB; step(10);
        chk("k2_state", key_state, 32'h4);
        chk("k2_event", key_event, 32'h4);
        chk("k2_count", key_count, exp_cnt(32'h1));
        key = 4'hF; step(10);
        chk("k2_rel_state", key_state, 32'h0);
        chk("k2_rel_event", key_event, 32'h4);
        ev_clr = 4'h4; step(1); ev_clr = 4'h0;
        chk("k2_clr_event", key_event, 32'h0);
        chk("k2_clr_count", key_count, exp_cnt(32'h1));

        // key[0] and key[3] together: +2 on exactly one edge.
        key = 4'h6; step(5);
        chk("k03_pre_count", key_count, exp_cnt(32'h1));
        step(1);
        chk("k03_count", key_count, exp_cnt(32'h3));
        chk("k03_state", key_state, 32'h9);
        key = 4'hF; step(10);
        ev_clr = 4'hF; step(1); ev_clr = 4'h0;
        chk("k03_clr_event", key_event, 32'h0);

        // ev_clr[1] coinciding with key[1] press: set wins.
        key = 4'hD; step(5);
        ev_clr = 4'h2; step(1); ev_clr = 4'h0;
        chk("k1_setwins", key_event, 32'h2);
        chk("k1_count", key_count, exp_cnt(32'h4));
        key = 4'hF; step(10);

        // cnt_clr coinciding with a key[0] press loads 1.
        key = 4'hE; step(5);
        chk("cclr_pre_count", key_count, exp_cnt(32'h4));
        cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        chk("cclr_load", key_count, exp_cnt(32'h1));
        ev_clr = 4'hF; step(1); ev_clr = 4'h0;
        key = 4'hF; step(10);
        chk("release_no_event", key_event, 32'h0);
        chk("release_count", key_count, exp_cnt(32'h1));
        cnt_clr = 1'b1; step(1); cnt_clr = 1'b0;
        chk("cclr_zero", key_count, 32'h0);

        // Reset mid-debounce on key[3] discards the pending change.
        key = 4'h7; step(3);
        reset = 1'b1; step(1); reset = 1'b0;
        chk("rstmid_event", key_event, 32'h0);
        chk("rstmid_sw", sw_value, 32'h0);
        step(5);
        chk("rstmid_state_e5", key_state, 32'h0);
        step(1);
        chk("rstmid_state_e6", key_state, 32'h8);
        chk("rstmid_ev_e6", key_event, 32'h8);
        chk("rstmid_cnt_e6", key_count, exp_cnt(32'h1));
        key = 4'hF; step(10);

`ifdef IO_PRESS_COUNT_EN
        // Wrap: 16383 rounds of four simultaneous presses, then 3, then 1.
        for (int r = 0; r < 16383; r++) begin
            w_key = 4'h0; step(2);
            w_key = 4'hF; step(2);
        end
        step(8);
        chk("wrap_fffc", w_key_count, 32'h0000FFFC);
        w_key = 4'h8; step(2); w_key = 4'hF; step(8);
        chk("wrap_ffff", w_key_count, 32'h0000FFFF);
        w_key = 4'hE; step(2); w_key = 4'hF; step(8);
        chk("wrap_zero", w_key_count, 32'h0);
        chk("wrap_event", w_key_event, 32'hF);
`else
        w_key = 4'hE; step(2); w_key = 4'hF; step(8);
        chk("nocnt_count", w_key_count, 32'h0);
        chk("nocnt_event", w_key_event, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
